// File: rtl/arith_op_pipe.sv
// arith_op_pipe: operand FIFO + add/sub/le/pass-A stage + held result register.
//
// Operand pairs {op, a, b} are queued behind a valid/ready handshake. The FIFO
// head is evaluated combinationally and loaded into the output register
// whenever that register is empty or being drained. One operation per clock.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready = FIFO not full
//   in_op               00 add, 01 sub, 10 le-compare, 11 pass-A
//   in_a, in_b          WIDTH-bit operands
//   out_valid/out_ready result handshake
//   out_res             WIDTH+1-bit result
//   out_op              op code that produced out_res
//   fifo_level          FIFO occupancy, 0..DEPTH
//   out_zero, out_ovf   status flags, present only with ARITH_PIPE_STATUS_EN
//
// Optional feature macro: ARITH_PIPE_STATUS_EN

module arith_op_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH:0]           out_res,
    output logic [1:0]               out_op,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef ARITH_PIPE_STATUS_EN
    ,
    output logic                     out_zero,
    output logic                     out_ovf
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_next;
    logic            empty;
    logic            push;
    logic            pop;
    entry_t          head;
    logic [WIDTH:0]  a_ext;
    logic [WIDTH:0]  b_ext;
    logic [WIDTH:0]  res_c;

    assign empty = (fifo_level == '0);
    // in_ready is a registered !full, so it never depends on a same-cycle pop
    assign push  = in_valid && in_ready;
    assign pop   = !empty && (!out_valid || out_ready);

    // Occupancy update
    always_comb begin
        level_next = fifo_level;
        if (push && !pop) begin
            level_next = fifo_level + LW'(1);
        end else if (!push && pop) begin
            level_next = fifo_level - LW'(1);
        end
    end

    // Pointers, level and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            in_ready   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= level_next;
            in_ready   <= (level_next != LW'(DEPTH));
        end
    end

    // Storage needs no reset: the head is only consumed when the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
        end
    end

    // Head evaluation; an empty FIFO yields a zero head so no X reaches the mux
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr];
        end
        a_ext = {1'b0, head.a};
        b_ext = {1'b0, head.b};
        case (head.op)
            2'b00:   res_c = a_ext + b_ext;
            2'b01:   res_c = a_ext - b_ext;
            2'b10:   res_c = {{WIDTH{1'b0}}, (head.a <= head.b)};
            default: res_c = a_ext;
        endcase
    end

    // Result register: load on pop, clear valid on drain, hold data otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_op    <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_res   <= res_c;
            out_op    <= head.op;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARITH_PIPE_STATUS_EN
    logic zero_c;
    logic ovf_c;

    // Signed overflow of the WIDTH-bit add/sub, zero detect on the low WIDTH bits
    always_comb begin
        zero_c = (res_c[WIDTH-1:0] == '0);
        ovf_c  = 1'b0;
        case (head.op)
            2'b00: ovf_c = (head.a[WIDTH-1] == head.b[WIDTH-1]) &&
                           (res_c[WIDTH-1] != head.a[WIDTH-1]);
            2'b01: ovf_c = (head.a[WIDTH-1] != head.b[WIDTH-1]) &&
                           (res_c[WIDTH-1] != head.a[WIDTH-1]);
            default: ovf_c = 1'b0;
        endcase
    end

    // Status flags travel with out_res
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (pop) begin
            out_zero <= zero_c;
            out_ovf  <= ovf_c;
        end
    end
`endif

endmodule

// File: tb/tb_arith_op_pipe.sv
// Self-checking bench for arith_op_pipe (WIDTH=8, DEPTH=4).
// Accepted operations push their expected {op,res} into a queue; a negedge
// monitor pops and compares each result as the consumer takes it.

module tb_arith_op_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_res;
    logic [1:0]  out_op;
    logic [2:0]  fifo_level;
`ifdef ARITH_PIPE_STATUS_EN
    logic        out_zero;
    logic        out_ovf;
`endif

    int checks   = 0;
    int failures = 0;
    logic [10:0] sbq[$];

    arith_op_pipe #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_op     (out_op),
        .fifo_level (fifo_level)
`ifdef ARITH_PIPE_STATUS_EN
        ,
        .out_zero   (out_zero),
        .out_ovf    (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers
    function automatic logic [8:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b) + 512;
            2'd2:    r = (a <= b) ? 1 : 0;
            default: r = int'(a);
        endcase
        return 9'(r % 512);
    endfunction

    // Present one operand pair for one edge; record expectation if accepted
    task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp, output bit acc);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        acc      = in_ready;
        if (acc) sbq.push_back({op, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check(tag, 16'(sbq.size()), 16'd0);
    endtask

    // Result monitor: compare each result the consumer accepts
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 16'(out_res), 16'hFFFF);
            end else begin
                check("result", 16'({out_op, out_res}), 16'(sbq[0]));
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_res", 16'(out_res), 16'd0);
        check("rst_out_op", 16'(out_op), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_level", 16'(fifo_level), 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: latency of a single add with carry
        out_ready = 1'b1;
        drive(2'd0, 8'hFF, 8'h01, 9'h100, acc);
        in_valid = 1'b0;
        check("t1_valid_edge1", 16'(out_valid), 16'd0);
        check("t1_level_edge1", 16'(fifo_level), 16'd1);
        @(posedge clk);
        #1;
        check("t1_valid_edge2", 16'(out_valid), 16'd1);
        check("t1_res", 16'(out_res), 16'h100);
        check("t1_op", 16'(out_op), 16'd0);
        check("t1_level_edge2", 16'(fifo_level), 16'd0);
        wait_drain("t1_drain");

        // 2: directed sub / le / pass-A
        drive(2'd1, 8'd3, 8'd5, 9'h1FE, acc);
        drive(2'd2, 8'd5, 8'd5, 9'h001, acc);
        drive(2'd2, 8'd6, 8'd5, 9'h000, acc);
        drive(2'd3, 8'hA5, 8'h3C, 9'h0A5, acc);
        in_valid = 1'b0;
        wait_drain("t2_drain");

        // 3: fill while stalled; six attempts, five accepted
        out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            op = 2'(i);
            a  = 8'(i * 37 + 3);
            b  = 8'(i * 11);
            drive(op, a, b, model(op, a, b), acc);
            n += int'(acc);
        end
        in_valid = 1'b0;
        check("t3_accepted", 16'(n), 16'd5);
        check("t3_level_full", 16'(fifo_level), 16'd4);
        check("t3_in_ready_full", 16'(in_ready), 16'd0);
        check("t3_held_valid", 16'(out_valid), 16'd1);
        check("t3_held_res", 16'({out_op, out_res}), 16'(sbq[0]));
        repeat (3) @(posedge clk);
        #1;
        check("t3_stable_res", 16'({out_op, out_res}), 16'(sbq[0]));
        check("t3_stable_level", 16'(fifo_level), 16'd4);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t3_drain_count", 16'(sbq.size()), 16'd0);
        check("t3_drain_valid", 16'(out_valid), 16'd0);
        check("t3_drain_level", 16'(fifo_level), 16'd0);

        // 4: continuous streaming, no bubbles
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            drive(op, a, b, model(op, a, b), acc);
            check("t4_accept", 16'(acc), 16'd1);
            if (i > 0) begin
                check("t4_level", 16'(fifo_level), 16'd1);
                check("t4_valid", 16'(out_valid), 16'd1);
            end
        end
        in_valid = 1'b0;
        wait_drain("t4_drain");

        // 5: reset mid-stream with queued and held results
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 8'(i), 8'(i + 1), model(2'd0, 8'(i), 8'(i + 1)), acc);
        end
        in_valid = 1'b0;
        check("t5_pre_level", 16'(fifo_level), 16'd3);
        check("t5_pre_valid", 16'(out_valid), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 16'(out_valid), 16'd0);
        check("t5_rst_level", 16'(fifo_level), 16'd0);
        check("t5_rst_in_ready", 16'(in_ready), 16'd1);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_stale_valid", 16'(out_valid), 16'd0);
        check("t5_no_stale_level", 16'(fifo_level), 16'd0);
        drive(2'd3, 8'h5A, 8'h00, 9'h05A, acc);
        in_valid = 1'b0;
        wait_drain("t5_drain");

`ifdef ARITH_PIPE_STATUS_EN
        // 6: status flags
        drive(2'd0, 8'h7F, 8'h01, 9'h080, acc);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_add_ovf", 16'(out_ovf), 16'd1);
        check("t6_add_zero", 16'(out_zero), 16'd0);
        drive(2'd1, 8'h04, 8'h04, 9'h000, acc);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_sub_zero", 16'(out_zero), 16'd1);
        check("t6_sub_ovf", 16'(out_ovf), 16'd0);
        wait_drain("t6_drain");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
